// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational fetch address and the IF/ID pipeline register.
// Optional feature: define MISALIGN_TRAP_EN to trap redirects to misaligned targets.
module fetch_unit #(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter int unsigned                ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = 32'h00000000,
    parameter logic [DATA_WIDTH-1:0]      NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] rd,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [ADDR_WIDTH-1:0] if_pc4,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic                  if_valid,
    output logic                  misalign_err
);

    typedef enum logic {StBoot, StRun} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;

    assign a        = pc;
    assign pc_plus4 = pc + ADDR_WIDTH'(4);

`ifndef MISALIGN_TRAP_EN
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StBoot;
            pc       <= RESET_PC;
            if_pc    <= '0;
            if_pc4   <= '0;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end
`ifdef MISALIGN_TRAP_EN
        // Once trapped, fetch is frozen with a bubble until reset.
        else if (misalign_err) begin
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
            if_instr     <= NOP_INSTR;
            if_valid     <= 1'b0;
        end
`endif
        else if (redirect) begin
            // Low bits are cleared so the PC always stays word aligned.
            pc       <= redirect_pc & ~ADDR_WIDTH'(3);
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (!stall) begin
            if (state == StBoot) begin
                state <= StRun;
            end
            pc       <= pc_plus4;
            if_pc    <= pc;
            if_pc4   <= pc_plus4;
            if_instr <= rd;
            if_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small combinational instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] rd;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        misalign_err;

    logic [31:0] mem [0:15];
    int total = 0;
    int bad = 0;

    assign rd = mem[a[5:2]];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .rd          (rd),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .misalign_err(misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step(); step();
        total++;
        if (a !== 32'h0 || if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h0 ||
            if_pc4 !== 32'h0 || misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: a=%h v=%b instr=%h pc=%h pc4=%h err=%b want a=0 v=0 instr=13 pc=0 pc4=0 err=0",
                     a, if_valid, if_instr, if_pc, if_pc4, misalign_err);
        end
        // Stalled first edge after release keeps IF/ID invalid.
        rst = 1'b0; stall = 1'b1;
        step();
        total++;
        if (a !== 32'h0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL boot_stall: a=%h v=%b want a=0 v=0", a, if_valid);
        end
        stall = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr [0:2];
        exp_instr[0] = 32'h00000513;
        exp_instr[1] = 32'h00100593;
        exp_instr[2] = 32'h00A00613;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (if_pc !== 32'(i * 4) || if_pc4 !== 32'(i * 4 + 4) || if_instr !== exp_instr[i] ||
                if_valid !== 1'b1 || a !== 32'(i * 4 + 4)) begin
                bad++;
                $display("FAIL seq_%0d: pc=%h pc4=%h instr=%h v=%b a=%h want pc=%h pc4=%h instr=%h v=1 a=%h",
                         i, if_pc, if_pc4, if_instr, if_valid, a,
                         32'(i * 4), 32'(i * 4 + 4), exp_instr[i], 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (a !== 32'h8 || if_pc !== 32'h4 || if_instr !== 32'h00100593 || if_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold_%0d: a=%h pc=%h instr=%h v=%b want a=8 pc=4 instr=00100593 v=1",
                         i, a, if_pc, if_instr, if_valid);
            end
        end
        stall = 1'b0;
        step();
        total++;
        if (if_pc !== 32'h8 || if_instr !== 32'h00A00613 || if_valid !== 1'b1 || a !== 32'hC) begin
            bad++;
            $display("FAIL stall_resume: pc=%h instr=%h v=%b a=%h want pc=8 instr=00a00613 v=1 a=c",
                     if_pc, if_instr, if_valid, a);
        end
    endtask

    task automatic test_redirect();
        step(); step();  // if_pc 0xC then 0x10
        total++;
        if (if_pc !== 32'h10 || if_instr !== 32'h00C00693 || a !== 32'h14) begin
            bad++;
            $display("FAIL pre_redirect: pc=%h instr=%h a=%h want pc=10 instr=00c00693 a=14",
                     if_pc, if_instr, a);
        end
        redirect = 1'b1; redirect_pc = 32'hC;
        step();
        total++;
        if (if_valid !== 1'b0 || if_instr !== 32'h13 || a !== 32'hC) begin
            bad++;
            $display("FAIL redirect_bubble: v=%b instr=%h a=%h want v=0 instr=13 a=c", if_valid, if_instr, a);
        end
        redirect = 1'b0;
        step();
        total++;
        if (if_pc !== 32'hC || if_instr !== 32'h00060C63 || if_valid !== 1'b1 || if_pc4 !== 32'h10) begin
            bad++;
            $display("FAIL redirect_target: pc=%h instr=%h v=%b pc4=%h want pc=c instr=00060c63 v=1 pc4=10",
                     if_pc, if_instr, if_valid, if_pc4);
        end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h20;
        step();
        total++;
        if (a !== 32'h20 || if_valid !== 1'b0 || if_instr !== 32'h13) begin
            bad++;
            $display("FAIL redir_stall: a=%h v=%b instr=%h want a=20 v=0 instr=13", a, if_valid, if_instr);
        end
        redirect = 1'b0;
        step();
        total++;
        if (a !== 32'h20 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_stall_hold: a=%h v=%b want a=20 v=0", a, if_valid);
        end
        stall = 1'b0;
        step();
        total++;
        if (if_pc !== 32'h20 || if_instr !== 32'h00B50533 || if_valid !== 1'b1) begin
            bad++;
            $display("FAIL redir_stall_fetch: pc=%h instr=%h v=%b want pc=20 instr=00b50533 v=1",
                     if_pc, if_instr, if_valid);
        end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h4;
        step();
        redirect_pc = 32'h8;
        step();
        total++;
        if (a !== 32'h8 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_last_wins: a=%h v=%b want a=8 v=0", a, if_valid);
        end
        redirect = 1'b0;
        step();
        total++;
        if (if_pc !== 32'h8 || if_instr !== 32'h00A00613 || if_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_fetch: pc=%h instr=%h v=%b want pc=8 instr=00a00613 v=1",
                     if_pc, if_instr, if_valid);
        end
    endtask

    task automatic test_misalign();
        step();  // a = 0x10
        redirect = 1'b1; redirect_pc = 32'hE;
        step();
        redirect = 1'b0;
        total++;
`ifdef MISALIGN_TRAP_EN
        if (a !== 32'h10 || misalign_err !== 1'b1 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL misalign_trap: a=%h err=%b v=%b want a=10 err=1 v=0", a, misalign_err, if_valid);
        end
        step();
        total++;
        if (a !== 32'h10 || misalign_err !== 1'b1 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL misalign_sticky: a=%h err=%b v=%b want a=10 err=1 v=0", a, misalign_err, if_valid);
        end
`else
        if (a !== 32'hC || misalign_err !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL misalign_force: a=%h err=%b v=%b want a=c err=0 v=0", a, misalign_err, if_valid);
        end
        step();
        total++;
        if (if_pc !== 32'hC || if_instr !== 32'h00060C63 || if_valid !== 1'b1 || misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL misalign_fetch: pc=%h instr=%h v=%b err=%b want pc=c instr=00060c63 v=1 err=0",
                     if_pc, if_instr, if_valid, misalign_err);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        total++;
        if (a !== 32'h14 || if_pc !== 32'h10) begin
            bad++;
            $display("FAIL run_to_20: a=%h pc=%h want a=14 pc=10", a, if_pc);
        end
        // Reset wins over concurrent redirect and stall.
        rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h30;
        step();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        total++;
        if (a !== 32'h0 || if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h0 ||
            misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun: a=%h v=%b instr=%h pc=%h err=%b want a=0 v=0 instr=13 pc=0 err=0",
                     a, if_valid, if_instr, if_pc, misalign_err);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
        step();
        redirect = 1'b0;
        total++;
        if (a !== 32'hFFFFFFFC) begin
            bad++;
            $display("FAIL wrap_load: a=%h want fffffffc", a);
        end
        step();
        total++;
        if (if_pc !== 32'hFFFFFFFC || if_pc4 !== 32'h0 || a !== 32'h0 || if_instr !== 32'h0000006F ||
            if_valid !== 1'b1 || misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL wrap: pc=%h pc4=%h a=%h instr=%h v=%b err=%b want pc=fffffffc pc4=0 a=0 instr=6f v=1 err=0",
                     if_pc, if_pc4, a, if_instr, if_valid, misalign_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h00000013;
        mem[0]  = 32'h00000513;
        mem[1]  = 32'h00100593;
        mem[2]  = 32'h00A00613;
        mem[3]  = 32'h00060C63;
        mem[4]  = 32'h00C00693;
        mem[8]  = 32'h00B50533;
        mem[15] = 32'h0000006F;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_back_to_back();
        test_misalign();
        test_reset_midrun();
        test_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
